// File: rtl/periph_reg_responder.sv
// Memory-mapped register responder: NB_REGS byte-writable registers, a saturating
// error counter and a fixed-latency response pipeline. Optional macro:
// PERIPH_REG_RESPONDER_SINGLE_OUTSTANDING_EN limits the block to one outstanding transaction.
module periph_reg_responder #(
  parameter int NB_REGS    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 9,
  parameter int LATENCY    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   add_i,
  input  logic                    wen_i,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              be_i,
  input  logic [ID_WIDTH-1:0]     id_i,
  output logic                    gnt_o,
  output logic                    r_valid_o,
  output logic [31:0]             r_rdata_o,
  output logic                    r_opc_o,
  output logic [ID_WIDTH-1:0]     r_id_o,
  output logic [NB_REGS*32-1:0]   regs_o
);

  localparam logic [8:0]  ERRCNT_IDX = 9'(NB_REGS);
  localparam logic [31:0] ERR_RDATA  = 32'hBADACCE5;

  logic [7:0]          idx;
  logic                misaligned;
  logic                is_reg;
  logic                is_errcnt;
  logic                is_err;
  logic                unused_addr_hi;

  logic [31:0]         regs_q [NB_REGS];
  logic [15:0]         errcnt_q;

  logic [31:0]         reg_rdata;
  logic [31:0]         rsp_rdata;
  logic                rsp_opc;

  logic                valid_q [LATENCY];
  logic [31:0]         rdata_q [LATENCY];
  logic                opc_q   [LATENCY];
  logic [ID_WIDTH-1:0] id_q    [LATENCY];

  // Only a 1 KiB window is decoded; the upper address bits are deliberately ignored.
  assign idx            = add_i[9:2];
  assign misaligned     = |add_i[1:0];
  assign unused_addr_hi = ^add_i[ADDR_WIDTH-1:10];

  assign is_reg    = !misaligned && ({1'b0, idx} <  ERRCNT_IDX);
  assign is_errcnt = !misaligned && ({1'b0, idx} == ERRCNT_IDX);
  assign is_err    = !is_reg && !is_errcnt;

`ifdef PERIPH_REG_RESPONDER_SINGLE_OUTSTANDING_EN
  logic any_valid;

  always_comb begin
    any_valid = 1'b0;
    for (int s = 0; s < LATENCY; s++) begin
      any_valid = any_valid | valid_q[s];
    end
  end

  assign gnt_o = req_i && !rst_i && !any_valid;
`else
  assign gnt_o = req_i && !rst_i;
`endif

  always_comb begin
    reg_rdata = 32'h0;
    for (int k = 0; k < NB_REGS; k++) begin
      if (idx == 8'(k)) begin
        reg_rdata = regs_q[k];
      end
    end
  end

  // Errors win over the write-response rule, so an erroneous write still reports BADACCE5.
  always_comb begin
    rsp_rdata = 32'h0;
    rsp_opc   = 1'b0;
    if (is_err) begin
      rsp_rdata = ERR_RDATA;
      rsp_opc   = 1'b1;
    end else if (wen_i) begin
      rsp_rdata = is_errcnt ? {16'h0, errcnt_q} : reg_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NB_REGS; k++) begin
        regs_q[k] <= 32'h0;
      end
      errcnt_q <= 16'h0;
    end else if (gnt_o) begin
      if (is_reg && !wen_i) begin
        for (int k = 0; k < NB_REGS; k++) begin
          if (idx == 8'(k)) begin
            for (int b = 0; b < 4; b++) begin
              if (be_i[b]) begin
                regs_q[k][8*b +: 8] <= wdata_i[8*b +: 8];
              end
            end
          end
        end
      end
      if (is_errcnt && !wen_i) begin
        errcnt_q <= 16'h0;
      end else if (is_err && (errcnt_q != 16'hFFFF)) begin
        errcnt_q <= errcnt_q + 16'd1;
      end
    end
  end

  // Stage 0 captures the response in the grant cycle; the last stage drives the outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < LATENCY; s++) begin
        valid_q[s] <= 1'b0;
        rdata_q[s] <= 32'h0;
        opc_q[s]   <= 1'b0;
        id_q[s]    <= '0;
      end
    end else begin
      valid_q[0] <= gnt_o;
      rdata_q[0] <= gnt_o ? rsp_rdata : 32'h0;
      opc_q[0]   <= gnt_o ? rsp_opc : 1'b0;
      id_q[0]    <= gnt_o ? id_i : '0;
      for (int s = 1; s < LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        rdata_q[s] <= rdata_q[s-1];
        opc_q[s]   <= opc_q[s-1];
        id_q[s]    <= id_q[s-1];
      end
    end
  end

  assign r_valid_o = valid_q[LATENCY-1];
  assign r_rdata_o = r_valid_o ? rdata_q[LATENCY-1] : 32'h0;
  assign r_opc_o   = r_valid_o ? opc_q[LATENCY-1] : 1'b0;
  assign r_id_o    = r_valid_o ? id_q[LATENCY-1] : '0;

  for (genvar k = 0; k < NB_REGS; k++) begin : g_regs_out
    assign regs_o[32*k +: 32] = regs_q[k];
  end

endmodule

// File: tb/tb_periph_reg_responder.sv
// Scoreboard bench for periph_reg_responder: stimulus pushes modelled responses,
// an independent monitor pops and compares them when r_valid_o appears.
module tb_periph_reg_responder;

  localparam int NB_REGS    = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int ID_WIDTH   = 9;
  localparam int LATENCY    = 3;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    req_i = 1'b0;
  logic [ADDR_WIDTH-1:0]   add_i = '0;
  logic                    wen_i = 1'b1;
  logic [31:0]             wdata_i = '0;
  logic [3:0]              be_i = '0;
  logic [ID_WIDTH-1:0]     id_i = '0;
  logic                    gnt_o;
  logic                    r_valid_o;
  logic [31:0]             r_rdata_o;
  logic                    r_opc_o;
  logic [ID_WIDTH-1:0]     r_id_o;
  logic [NB_REGS*32-1:0]   regs_o;

  periph_reg_responder #(
    .NB_REGS(NB_REGS), .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH), .LATENCY(LATENCY)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .id_i(id_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .r_id_o(r_id_o), .regs_o(regs_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]         rdata;
    logic                opc;
    logic [ID_WIDTH-1:0] id;
    int                  due;
  } rsp_t;

  rsp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_regs [NB_REGS];
  int          model_errcnt = 0;
  int          last_gnt = -100;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  function automatic logic [NB_REGS*32-1:0] modelFlat();
    logic [NB_REGS*32-1:0] v;
    for (int k = 0; k < NB_REGS; k++) v[32*k +: 32] = model_regs[k];
    return v;
  endfunction

  // Reference behaviour: decode by word index, update state, queue the response.
  task automatic modelAccess(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [ID_WIDTH-1:0] id);
    rsp_t e;
    int   idx;
    idx   = int'(addr[9:2]);
    e.id  = id;
    e.due = cyc + LATENCY;
    if (addr[1:0] != 2'b00 || idx > NB_REGS) begin
      e.rdata = 32'hBADACCE5;
      e.opc   = 1'b1;
      if (model_errcnt < 65535) model_errcnt++;
    end else if (idx == NB_REGS) begin
      e.opc   = 1'b0;
      e.rdata = wen ? 32'(model_errcnt) : 32'h0;
      if (!wen) model_errcnt = 0;
    end else begin
      e.opc = 1'b0;
      if (wen) begin
        e.rdata = model_regs[idx];
      end else begin
        e.rdata = 32'h0;
        for (int b = 0; b < 4; b++)
          if (be[b]) model_regs[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic wen,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [ID_WIDTH-1:0] id);
    logic exp_gnt;
    req_i = req; add_i = addr; wen_i = wen; wdata_i = wdata; be_i = be; id_i = id;
    @(negedge clk_i);
    checkOutput("regs_o", 256'(regs_o), 256'(modelFlat()));
`ifdef PERIPH_REG_RESPONDER_SINGLE_OUTSTANDING_EN
    exp_gnt = req && ((cyc - last_gnt) > LATENCY);
`else
    exp_gnt = req;
`endif
    checkOutput("gnt_o", 256'(gnt_o), 256'(exp_gnt));
    if (exp_gnt) begin
      modelAccess(addr, wen, wdata, be, id);
      last_gnt = cyc;
    end
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    req_i = 1'b1; add_i = 32'h0; wen_i = 1'b1;
    @(negedge clk_i);
    checkOutput("gnt_in_reset", 256'(gnt_o), 256'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    req_i = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NB_REGS; k++) model_regs[k] = 32'h0;
    model_errcnt = 0;
    last_gnt = -100;
    @(negedge clk_i);
    checkOutput("regs_after_reset", 256'(regs_o), 256'(0));
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: pops the oldest expectation whenever a response appears.
  always @(negedge clk_i) begin
    rsp_t e;
    if (!rst_i || cyc > 2) begin
      if (r_valid_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_r_valid", 256'(1), 256'(0));
        end else begin
          e = exp_q.pop_front();
          checkOutput("r_rdata_o", 256'(r_rdata_o), 256'(e.rdata));
          checkOutput("r_opc_o", 256'(r_opc_o), 256'(e.opc));
          checkOutput("r_id_o", 256'(r_id_o), 256'(e.id));
          checkOutput("rsp_cycle", 256'(cyc), 256'(e.due));
        end
      end else begin
        checkOutput("idle_outputs_zero", 256'({r_rdata_o, r_opc_o, r_id_o}), 256'(0));
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          checkOutput("missing_rsp_cycle", 256'(0), 256'(e.due));
        end
      end
    end
  end

  initial begin
    int          idx;
    logic [31:0] addr;
    for (int k = 0; k < NB_REGS; k++) model_regs[k] = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    doReset();

    $display("[TB] directed: byte-enabled write then read");
    applyStimulus(1'b1, 32'h0000_0008, 1'b0, 32'hDEADBEEF, 4'b0101, 9'h010);
    applyStimulus(1'b1, 32'h0000_0008, 1'b1, 32'h0, 4'b0000, 9'h010);
    checkOutput("reg2_after_write", 256'(regs_o[95:64]), 256'(32'h00AD00EF));

    $display("[TB] directed: back-to-back reads");
    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 32'h0, 4'h0, 9'h001);
    applyStimulus(1'b1, 32'h0000_0004, 1'b1, 32'h0, 4'h0, 9'h002);
    applyStimulus(1'b1, 32'h0000_0008, 1'b1, 32'h0, 4'h0, 9'h004);
    repeat (LATENCY + 1) applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 9'h0);

    $display("[TB] directed: error accesses and ERRCNT");
    doReset();
    applyStimulus(1'b1, 32'h1020_0402, 1'b1, 32'h0, 4'h0, 9'h008);
    applyStimulus(1'b1, 32'((NB_REGS + 5) * 4), 1'b1, 32'h0, 4'h0, 9'h020);
    applyStimulus(1'b1, 32'(NB_REGS * 4), 1'b1, 32'h0, 4'h0, 9'h040);
    applyStimulus(1'b1, 32'(NB_REGS * 4), 1'b0, 32'h1234_5678, 4'h0, 9'h080);
    applyStimulus(1'b1, 32'(NB_REGS * 4), 1'b1, 32'h0, 4'h0, 9'h100);

    $display("[TB] directed: ERRCNT saturation");
    repeat (65540) applyStimulus(1'b1, 32'h0000_03FC, 1'b1, 32'h0, 4'h0, 9'h001);
    applyStimulus(1'b1, 32'(NB_REGS * 4), 1'b1, 32'h0, 4'h0, 9'h002);
    repeat (LATENCY + 1) applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 9'h0);

    $display("[TB] directed: reset with a read in flight");
    applyStimulus(1'b1, 32'h0000_0004, 1'b0, 32'hCAFE_F00D, 4'hF, 9'h004);
    applyStimulus(1'b1, 32'h0000_0004, 1'b1, 32'h0, 4'h0, 9'h008);
    doReset();
    repeat (LATENCY + 1) applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 9'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) doReset();
      case ($urandom_range(0, 15))
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9: idx = int'($urandom_range(0, NB_REGS - 1));
        10, 11:                       idx = NB_REGS;
        default:                      idx = int'($urandom_range(NB_REGS + 1, 255));
      endcase
      addr      = $urandom();
      addr[9:2] = 8'(idx);
      addr[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus($urandom_range(0, 9) != 0, addr, 1'($urandom_range(0, 1)), $urandom(),
                    4'($urandom_range(0, 15)), 9'(1 << $urandom_range(0, ID_WIDTH - 1)));
    end

    repeat (LATENCY + 2) applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 9'h0);
    checkOutput("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/periph_reg_responder.md
PERIPH_REG_RESPONDER -- requirements
Module: periph_reg_responder

Interface
REQ-001 SHALL have parameter NB_REGS, default 8, number of read/write 32-bit registers (1..255).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of add_i.
REQ-003 SHALL have parameter ID_WIDTH, default 9, width of the one-hot initiator ID (NB_CORES+NB_MPERIPHS).
REQ-004 SHALL have parameter LATENCY, default 1, cycles from grant to r_valid_o (1..4).
REQ-005 SHALL have port clk_i  input  1  clock; single clock domain.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_i  input  1  request valid.
REQ-008 SHALL have port add_i  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port wen_i  input  1  0 = write, 1 = read.
REQ-010 SHALL have port wdata_i  input  32  write data.
REQ-011 SHALL have port be_i  input  4  byte enables for writes.
REQ-012 SHALL have port id_i  input  ID_WIDTH  initiator ID.
REQ-013 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-014 SHALL have port r_valid_o  output  1  response valid; no back-pressure, always consumed.
REQ-015 SHALL have port r_rdata_o  output  32  read data.
REQ-016 SHALL have port r_opc_o  output  1  0 = OK, 1 = error.
REQ-017 SHALL have port r_id_o  output  ID_WIDTH  echo of id_i of the granted request.
REQ-018 SHALL have port regs_o  output  NB_REGS*32  current register contents, reg k at bits [32k+31:32k].

Function
REQ-019 SHALL accept a transaction in any cycle with req_i && gnt_o.
REQ-020 SHALL decode word index idx = add_i[9:2] (1 KiB window); add_i[ADDR_WIDTH-1:10] ignored.
REQ-021 SHALL treat idx < NB_REGS as a RW register; writes update only bytes with be_i[b]=1, and take effect at the end of the grant cycle.
REQ-022 SHALL treat idx == NB_REGS as ERRCNT: reads return {16'h0, count}; writes clear count to 0 regardless of be_i, with opc 0.
REQ-023 SHALL treat idx > NB_REGS or add_i[1:0] != 0 as an error: no state change except ERRCNT, rdata 32'hBADACCE5, opc 1.
REQ-024 SHALL increment the 16-bit ERRCNT by 1 per error access, saturating at 16'hFFFF.
REQ-025 SHALL return write responses with rdata 32'h0 and opc 0 (non-error).
REQ-026 SHALL capture read data, opc and id in the grant cycle T and present them with r_valid_o=1 in exactly cycle T+LATENCY, one cycle wide, through a LATENCY-stage valid/data shift pipeline.
REQ-027 SHALL return a read in cycle T+1 or later of a register written in cycle T with the new value.
REQ-028 SHALL preserve request order; responses SHALL never merge or drop, sustaining one response per cycle.
REQ-029 SHALL drive r_rdata_o, r_opc_o and r_id_o to 0 whenever r_valid_o=0.

Reset
REQ-030 SHALL, on rst_i=1 at a clock edge, clear all registers, ERRCNT and pipeline valid bits to 0; outputs are 0 the following cycle.
REQ-031 SHALL drop in-flight responses on reset mid-operation; no r_valid_o SHALL appear for transactions granted before reset.
REQ-032 SHALL hold gnt_o=0 during cycles with rst_i=1.

Configuration
REQ-033 SHALL, with macro PERIPH_REG_RESPONDER_SINGLE_OUTSTANDING_EN undefined, drive gnt_o = req_i && !rst_i (full throughput).
REQ-034 SHALL, with PERIPH_REG_RESPONDER_SINGLE_OUTSTANDING_EN defined, drive gnt_o = req_i && !rst_i && no valid in any pipeline stage, allowing at most one outstanding transaction; with LATENCY=1, back-to-back requests are granted every second cycle.

Verification
REQ-035 SHALL cover: write reg 2 = 32'hDEADBEEF, be 4'b0101 after reset, then read -> r_rdata_o 32'h00AD00EF, opc 0, r_id_o equals id_i, at T+LATENCY.
REQ-036 SHALL cover: LATENCY=3, reads of idx 0,1,2 on consecutive cycles -> three consecutive r_valid_o pulses at T+3..T+5 with matching IDs 9'h001, 9'h002, 9'h004.
REQ-037 SHALL cover: read add_i=0x1020_0402 (misaligned), then read idx NB_REGS+5 -> both opc 1 and rdata 32'hBADACCE5; ERRCNT read returns 2; write ERRCNT -> reads 0.
REQ-038 SHALL cover: 65540 error accesses -> ERRCNT reads 16'hFFFF.
REQ-039 SHALL cover: rst_i asserted for 1 cycle at T+1 after a read with LATENCY=2 -> no r_valid_o, all regs_o 0.
REQ-040 SHALL cover: with PERIPH_REG_RESPONDER_SINGLE_OUTSTANDING_EN, LATENCY=1, req_i held high 6 cycles -> gnt_o pattern 1,0,1,0,1,0.
